axis_sa_arbiter: RTL and testbench

Shares one `axis_sa` systolic-array instance between N AXI-Stream requesters, with packet-atomic round-robin arbitration. Each requester sends a packet of input beats (x row vector plus k column vector, terminated by `s_last`) and receives the matching output packet (C beats, terminated by `m_last`). A tag FIFO records the issuing requester of every packet in flight, so that array outputs are routed back in issue order.

---
 rtl/axis_sa_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axis_sa_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sa_arbiter.sv
// Packet-atomic round-robin arbiter that shares one systolic-array instance between N AXI-Stream requesters.
// A tag FIFO remembers the issuing requester of each packet so array outputs are routed back in issue order.
module axis_sa_arbiter #(
  parameter int N     = 2,
  parameter int R     = 4,
  parameter int C     = 8,
  parameter int WX    = 4,
  parameter int WK    = 8,
  parameter int WY    = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N-1:0]          s_valid,
  input  logic [N-1:0]          s_last,
  output logic [N-1:0]          s_ready,
  input  logic [N*R*WX-1:0]     sx_data,
  input  logic [N*C*WK-1:0]     sk_data,
  output logic                  a_s_valid,
  output logic                  a_s_last,
  input  logic                  a_s_ready,
  output logic [R*WX-1:0]       a_sx_data,
  output logic [C*WK-1:0]       a_sk_data,
  input  logic                  a_m_valid,
  input  logic                  a_m_last,
  output logic                  a_m_ready,
  input  logic [R*WY-1:0]       a_m_data,
  output logic [N-1:0]          m_valid,
  output logic [N-1:0]          m_last,
  input  logic [N-1:0]          m_ready,
  output logic [R*WY-1:0]       m_data,
  output logic                  err
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = R * WX;
  localparam int KW = C * WK;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] tag_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic [GW-1:0] win_s;
  logic          win_found_s;
  logic [GW:0]   idx_s;
  logic          hit_s;
  logic [GW-1:0] head_s;
  logic          nonempty_s, full_s, push_s, pop_s, in_last_hs_s, err_set_s;
  logic [XW-1:0] sx_arr_s [N];
  logic [KW-1:0] sk_arr_s [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign sx_arr_s[g] = sx_data[g*XW +: XW];
    assign sk_arr_s[g] = sk_data[g*KW +: KW];
  end

  assign head_s       = tag_q[rd_ptr_q];
  assign nonempty_s   = (count_q != '0);
  assign full_s       = (count_q == CW'(DEPTH));
  assign push_s       = (state_q == IDLE) & win_found_s & ~full_s;
  assign pop_s        = a_m_valid & a_m_ready & a_m_last;
  assign in_last_hs_s = a_s_valid & a_s_ready & a_s_last;
  // a_m_valid with no tag outstanding, or a last-beat handshake outside BUSY
  assign err_set_s    = (a_m_valid & ~nonempty_s) |
                        ((state_q != BUSY) & (|(s_valid & s_ready & s_last)));

  // Round-robin search starting at rr_q, wrapping modulo N
  always_comb begin
    win_s       = rr_q;
    win_found_s = 1'b0;
    idx_s       = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s       = {1'b0, rr_q} + (GW+1)'(k);
      idx_s       = (idx_s >= (GW+1)'(N)) ? idx_s - (GW+1)'(N) : idx_s;
      hit_s       = ~win_found_s & s_valid[idx_s[GW-1:0]];
      win_s       = hit_s ? idx_s[GW-1:0] : win_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Controller state, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_q | err_set_s;
    end
  end

  // Next-state: grant from IDLE, release after the last beat of the packet
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (push_s) begin
          state_d = BUSY;
          grant_d = win_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (in_last_hs_s) begin
          state_d = IDLE;
          rr_d    = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and data muxes toward the array and back to the requesters
  always_comb begin
    s_ready   = '0;
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
    a_sx_data = sx_arr_s[grant_q];
    a_sk_data = sk_arr_s[grant_q];
    if (state_q == BUSY) begin
      a_s_valid        = s_valid[grant_q];
      a_s_last         = s_last[grant_q];
      s_ready[grant_q] = a_s_ready;
    end else begin
      a_s_valid = 1'b0;
      a_s_last  = 1'b0;
    end
    m_valid         = '0;
    m_last          = '0;
    m_valid[head_s] = a_m_valid & nonempty_s;
    m_last[head_s]  = a_m_valid & nonempty_s & a_m_last;
    a_m_ready       = nonempty_s & m_ready[head_s];
    m_data          = a_m_data;
    err             = err_q;
  end

  // Tag FIFO; push and pop in the same cycle leave the count unchanged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        tag_q[wr_ptr_q] <= win_s;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sa_arbiter.sv
// Directed bench for axis_sa_arbiter; the bench itself plays the role of the shared array.
module tb_axis_sa_arbiter;

  localparam int N = 2, R = 4, C = 8, WX = 4, WK = 8, WY = 16, DEPTH = 2;
  localparam int XW = R * WX, KW = C * WK, YW = R * WY;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [N-1:0]      s_valid = '0, s_last = '0, s_ready;
  logic [N*XW-1:0]   sx_data = '0;
  logic [N*KW-1:0]   sk_data = '0;
  logic              a_s_valid, a_s_last;
  logic              a_s_ready = 1'b0;
  logic [XW-1:0]     a_sx_data;
  logic [KW-1:0]     a_sk_data;
  logic              a_m_valid = 1'b0, a_m_last = 1'b0;
  logic              a_m_ready;
  logic [YW-1:0]     a_m_data = '0;
  logic [N-1:0]      m_valid, m_last;
  logic [N-1:0]      m_ready = '1;
  logic [YW-1:0]     m_data;
  logic              err;

  int total = 0;
  int bad   = 0;

  axis_sa_arbiter #(.N(N), .R(R), .C(C), .WX(WX), .WK(WK), .WY(WY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .sx_data(sx_data), .sk_data(sk_data),
    .a_s_valid(a_s_valid), .a_s_last(a_s_last), .a_s_ready(a_s_ready),
    .a_sx_data(a_sx_data), .a_sk_data(a_sk_data),
    .a_m_valid(a_m_valid), .a_m_last(a_m_last), .a_m_ready(a_m_ready),
    .a_m_data(a_m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .m_data(m_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One packet from requester req: an IDLE cycle, then len beats that must all go straight through
  task automatic send_pkt(input int req, input int len, input logic [N-1:0] vmask);
    logic [N-1:0]  oh;
    logic [XW-1:0] x;
    logic [KW-1:0] k;
    oh = N'(1) << req;
    @(negedge clk);
    s_valid   = vmask;
    s_last    = '0;
    a_s_ready = 1'b1;
    #1;
    chk("gap_s_ready", s_ready, 0);
    chk("gap_a_s_valid", a_s_valid, 0);
    for (int b = 0; b < len; b++) begin
      @(negedge clk);
      x = XW'(32'h1000 * (req + 1) + b);
      k = {x, ~x, x ^ 16'h5A5A, x + 16'd3};
      for (int i = 0; i < N; i++) begin
        sx_data[i*XW +: XW] = (i == req) ? x : ~x;
        sk_data[i*KW +: KW] = (i == req) ? k : ~k;
      end
      s_last = (b == len - 1) ? oh : '0;
      #1;
      chk("beat_s_ready", s_ready, oh);
      chk("beat_a_s_valid", a_s_valid, 1);
      chk("beat_a_s_last", a_s_last, (b == len - 1));
      chk("beat_a_sx_data", a_sx_data, x);
      chk("beat_a_sk_data", a_sk_data, k);
    end
    @(posedge clk);
    #1;
    s_valid = '0;
    s_last  = '0;
  endtask

  // One output packet of nb beats, expected to be routed only to requester req
  task automatic drain(input int req, input int nb);
    logic [N-1:0]  oh;
    logic [YW-1:0] y;
    oh = N'(1) << req;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      y         = 64'hC0DE_0000_0000_0000 | (64'(req) << 8) | 64'(b);
      a_m_valid = 1'b1;
      a_m_last  = (b == nb - 1);
      a_m_data  = y;
      #1;
      chk("out_m_valid", m_valid, oh);
      chk("out_m_last", m_last, (b == nb - 1) ? oh : '0);
      chk("out_a_m_ready", a_m_ready, 1);
      chk("out_m_data", m_data, y);
    end
    @(posedge clk);
    #1;
    a_m_valid = 1'b0;
    a_m_last  = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_a_s_valid", a_s_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_a_m_ready", a_m_ready, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_s_ready", s_ready, 0);
    chk("post_rst_err", err, 0);

    // Single requester 1, three 4-beat packets; two back to back to check the 1-cycle gap
    send_pkt(1, 4, 2'b10);
    send_pkt(1, 4, 2'b10);
    drain(1, C);
    send_pkt(1, 4, 2'b10);
    drain(1, C);
    drain(1, C);

    // Contention: both requesting, grants alternate 0,1,0,1
    send_pkt(0, 2, 2'b11);
    send_pkt(1, 2, 2'b11);
    drain(0, C);
    drain(1, C);
    send_pkt(0, 2, 2'b11);
    send_pkt(1, 2, 2'b11);
    drain(0, C);
    drain(1, C);

    // FIFO full: two packets outstanding, third request held in IDLE
    m_ready = 2'b00;
    send_pkt(0, 2, 2'b01);
    send_pkt(1, 2, 2'b10);
    @(negedge clk);
    s_valid   = 2'b01;
    s_last    = 2'b00;
    a_m_valid = 1'b1;
    #1;
    chk("full_s_ready", s_ready, 0);
    chk("full_a_m_ready", a_m_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("full_hold_s_ready", s_ready, 0);
      chk("full_hold_a_s_valid", a_s_valid, 0);
    end
    m_ready = 2'b01;
    drain(0, C);
    @(negedge clk);
    s_last = 2'b01;
    #1;
    chk("refill_idle_s_ready", s_ready, 0);
    @(negedge clk);
    #1;
    chk("refill_grant_s_ready", s_ready, 2'b01);
    chk("refill_a_s_last", a_s_last, 1);
    @(posedge clk);
    #1;
    s_valid = '0;
    s_last  = '0;
    m_ready = 2'b11;
    drain(1, C);
    drain(0, C);

    // Head-of-line: tag order 0 then 1, requester 0 stalled
    send_pkt(0, 1, 2'b01);
    send_pkt(1, 1, 2'b10);
    m_ready = 2'b10;
    @(negedge clk);
    a_m_valid = 1'b1;
    a_m_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hol_a_m_ready", a_m_ready, 0);
      chk("hol_m_valid", m_valid, 2'b01);
      @(negedge clk);
    end
    m_ready = 2'b11;
    drain(0, C);
    drain(1, C);

    // Reset during beat 2 of a 4-beat packet
    @(negedge clk);
    s_valid   = 2'b01;
    s_last    = 2'b00;
    a_s_ready = 1'b1;
    @(negedge clk);
    a_m_valid = 1'b1;
    #1;
    chk("pre_rst_s_ready", s_ready, 2'b01);
    chk("pre_rst_m_valid", m_valid, 2'b01);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_a_s_valid", a_s_valid, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    s_valid   = '0;
    a_m_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    send_pkt(0, 4, 2'b01);
    drain(0, C);
    chk("after_rst_err", err, 0);

    // Protocol error: array output with no tag outstanding
    @(negedge clk);
    a_m_valid = 1'b1;
    a_m_last  = 1'b1;
    #1;
    chk("perr_a_m_ready", a_m_ready, 0);
    chk("perr_m_valid", m_valid, 0);
    chk("perr_m_last", m_last, 0);
    chk("perr_err_before", err, 0);
    @(posedge clk);
    #1;
    chk("perr_err_set", err, 1);
    @(negedge clk);
    a_m_valid = 1'b0;
    a_m_last  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("perr_err_held", err, 1);
    chk("perr_a_m_ready_idle", a_m_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
